// File: rtl/axil_pkg.sv
// ============================================================================
// axil_pkg - shared AXI4-Lite widths, master FSM state type, counter sizing
// Rev 1.0
// ============================================================================
`default_nettype none

package axil_pkg;

  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_STRB_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_R  = 3'd2,
    WR_AW = 3'd3,
    WR_B  = 3'd4
  } axim_state_e;

  // Bits needed to count 0 .. cycles-1.
  function automatic int axil_cnt_w(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axil_wdog.sv
// ============================================================================
// axil_wdog - clearable cycle counter; flags the cycle whose increment reaches LIMIT
// Rev 1.0
// ============================================================================
`default_nettype none

module axil_wdog #(
  parameter int CNT_W = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Fires one cycle early so the owner's registered response lands on LIMIT+1.
  assign expired = run && !clear && ((32'(cnt_q) + 32'd1) == 32'(LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_lite_master.sv
// ============================================================================
// axi_lite_master - single-outstanding core load/store to AXI4-Lite bridge
// Optional watchdog abort when AXIM_TIMEOUT_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module axi_lite_master
  import axil_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [AXIL_ADDR_W-1:0] req_addr,
  input  logic [AXIL_DATA_W-1:0] req_wdata,
  input  logic [AXIL_STRB_W-1:0] req_wstrb,
  output logic                   rsp_valid,
  output logic [AXIL_DATA_W-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic [AXIL_ADDR_W-1:0] araddr,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [AXIL_DATA_W-1:0] rdata,
  input  logic                   rvalid,
  output logic                   rready,
  output logic [AXIL_ADDR_W-1:0] awaddr,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [AXIL_DATA_W-1:0] wdata,
  output logic [AXIL_STRB_W-1:0] wstrb,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic                   bvalid,
  output logic                   bready
);

  axim_state_e            state_q,     state_d;
  logic [AXIL_ADDR_W-1:0] addr_q,      addr_d;
  logic [AXIL_DATA_W-1:0] wdata_q,     wdata_d;
  logic [AXIL_STRB_W-1:0] wstrb_q,     wstrb_d;
  logic                   arvalid_q,   arvalid_d;
  logic                   aw_pend_q,   aw_pend_d;
  logic                   w_pend_q,    w_pend_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q,   rsp_err_d;
  logic [AXIL_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic accept;
  logic done;
  logic wd_expired;
  logic abort;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign done      = ((state_q == RD_R) && rvalid) || ((state_q == WR_B) && bvalid);
  assign abort     = wd_expired && !done;

`ifdef AXIM_TIMEOUT_EN
  axil_wdog #(
    .CNT_W (axil_cnt_w(TIMEOUT_CYCLES)),
    .LIMIT (TIMEOUT_CYCLES - 1)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .run     (state_q != IDLE),
    .expired (wd_expired)
  );
`else
  // No watchdog: the abort path can never fire.
  assign wd_expired = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    arvalid_d   = arvalid_q;
    aw_pend_d   = aw_pend_q;
    w_pend_d    = w_pend_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (req_we) begin
            state_d   = WR_AW;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
          end else begin
            state_d   = RD_A;
            arvalid_d = 1'b1;
          end
        end
      end
      RD_A: begin
        if (arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        if (rvalid) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rdata;
          state_d     = IDLE;
        end
      end
      WR_AW: begin
        // AW and W retire independently; B is awaited only once both have.
        aw_pend_d = aw_pend_q && !awready;
        w_pend_d  = w_pend_q && !wready;
        if (!aw_pend_d && !w_pend_d) begin
          state_d = WR_B;
        end
      end
      WR_B: begin
        if (bvalid) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d     = IDLE;
      arvalid_d   = 1'b0;
      aw_pend_d   = 1'b0;
      w_pend_d    = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      arvalid_q   <= 1'b0;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      arvalid_q   <= arvalid_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign araddr    = {addr_q[AXIL_ADDR_W-1:2], 2'b00};
  assign arvalid   = arvalid_q;
  assign rready    = (state_q == RD_R);
  assign awaddr    = addr_q;
  assign awvalid   = aw_pend_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wvalid    = w_pend_q;
  assign bready    = (state_q == WR_B);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_master.sv
// ============================================================================
// tb_axi_lite_master - randomized bench with behavioural memory/latency model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axi_lite_master;

  localparam int TO_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  axi_lite_master #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] slv_mem [256];
  logic [31:0] ref_mem [256];

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = ref_mem[a[9:2]];
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[a[9:2]] = w;
  endfunction

  // Zero-wait cost is 3 cycles; every stall cycle adds one.
  function automatic int exp_lat(input logic we, input int d1, input int d2, input int d3);
    if (we) return 3 + ((d1 > d2) ? d1 : d2) + d3;
    return 3 + d1 + d2;
  endfunction

  // Issues one request and plays the slave: d1/d2/d3 are AR/R or AW/W/B stall cycles.
  task automatic run_txn(
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [3:0]  ws,
    input  int          d1,
    input  int          d2,
    input  int          d3,
    output int          lat,
    output int          waitc,
    output logic [31:0] rd,
    output logic        err,
    output logic        rdy,
    output logic [31:0] hs_addr,
    output logic        ok
  );
    logic ar_done, r_given, aw_done, w_done, b_given, mem_wr, both_prev;
    logic ar_seen, aw_seen, w_seen;
    logic [31:0] h_ar, h_aw, h_wd, s_awaddr, s_wdata;
    logic [3:0]  h_ws, s_wstrb;
    int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    ar_done = 0; r_given = 0; aw_done = 0; w_done = 0; b_given = 0; mem_wr = 0;
    ar_seen = 0; aw_seen = 0; w_seen = 0;
    h_ar = '0; h_aw = '0; h_wd = '0; h_ws = '0; s_awaddr = '0; s_wdata = '0; s_wstrb = '0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
    lat = -1; waitc = 0; rd = '0; err = 1'b0; rdy = 1'b0; hs_addr = '0; ok = 1'b1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_wstrb = ws;
    while (!req_ready && waitc < 50) begin
      @(posedge clk); @(negedge clk); waitc++;
    end
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom_range(0, 1));
    req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom_range(0, 15));
    for (int c = 1; c <= 200; c++) begin
      arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; rdata = $urandom;
      if (rsp_valid) begin
        lat = c; rd = rsp_rdata; err = rsp_err; rdy = req_ready;
        break;
      end
      if (!we) begin
        if (awvalid || wvalid || bready) ok = 0;
        if (!ar_done) begin
          if (rready) ok = 0;
          if (arvalid) begin
            if (ar_seen && araddr !== h_ar) ok = 0;
            ar_seen = 1; h_ar = araddr;
            if (ar_cnt >= d1) begin arready = 1; ar_done = 1; hs_addr = araddr; end
            ar_cnt++;
          end else if (ar_seen) ok = 0;
        end else begin
          if (arvalid || !rready) ok = 0;
          if (!r_given) begin
            if (r_cnt >= d2) begin rvalid = 1; rdata = slv_mem[hs_addr[9:2]]; r_given = 1; end
            r_cnt++;
          end
        end
      end else begin
        both_prev = aw_done && w_done;
        if (arvalid || rready) ok = 0;
        if (!aw_done) begin
          if (awvalid) begin
            if (aw_seen && awaddr !== h_aw) ok = 0;
            aw_seen = 1; h_aw = awaddr;
            if (aw_cnt >= d1) begin awready = 1; aw_done = 1; s_awaddr = awaddr; hs_addr = awaddr; end
            aw_cnt++;
          end else if (aw_seen) ok = 0;
        end else if (awvalid) ok = 0;
        if (!w_done) begin
          if (wvalid) begin
            if (w_seen && (wdata !== h_wd || wstrb !== h_ws)) ok = 0;
            w_seen = 1; h_wd = wdata; h_ws = wstrb;
            if (w_cnt >= d2) begin wready = 1; w_done = 1; s_wdata = wdata; s_wstrb = wstrb; end
            w_cnt++;
          end else if (w_seen) ok = 0;
        end else if (wvalid) ok = 0;
        if (!both_prev) begin
          if (bready) ok = 0;
        end else begin
          if (!bready) ok = 0;
          if (!b_given) begin
            if (b_cnt >= d3) begin bvalid = 1; b_given = 1; end
            b_cnt++;
          end
        end
        if (aw_done && w_done && !mem_wr) begin
          mem_wr = 1;
          for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) slv_mem[s_awaddr[9:2]][8*b +: 8] = s_wdata[8*b +: 8];
        end
      end
      @(posedge clk); @(negedge clk);
    end
    arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
  endtask

  task automatic test_reset();
    logic [131:0] v;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready_low: got %b want 0", req_ready); end
    rst = 1'b0; #1;
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready_idle: got %b want 1", req_ready); end
    n_tests++;
    if ({arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000000", {arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err});
    end
    v = {araddr, awaddr, wdata, wstrb, rsp_rdata};
    n_tests++;
    if (v !== 132'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", v); end
  endtask

  task automatic test_sram_read();
    int lat, wc; logic [31:0] rd, ha; logic err, rdy, ok;
    run_txn(1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, 0, 0, lat, wc, rd, err, rdy, ha, ok);
    n_tests++;
    if (ha !== 32'h104) begin n_fail++; $display("FAIL sram_read_araddr: got %h want 00000104", ha); end
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL sram_read_latency: got %0d want 3", lat); end
    n_tests++;
    if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sram_read_data: got %h want deadbeef", rd); end
    n_tests++;
    if ({err, ok} !== 2'b01) begin n_fail++; $display("FAIL sram_read_err_proto: got err=%b ok=%b want 0 1", err, ok); end
  endtask

  task automatic test_strobe_write();
    int lat, wc; logic [31:0] rd, ha; logic err, rdy, ok;
    run_txn(1'b1, 32'h0000_0200, 32'h1122_3344, 4'b0101, 0, 0, 0, lat, wc, rd, err, rdy, ha, ok);
    ref_write(32'h200, 32'h1122_3344, 4'b0101);
    n_tests++;
    if (lat !== 3 || rd !== 32'h0 || ok !== 1'b1) begin
      n_fail++; $display("FAIL strobe_write_rsp: got lat=%0d rdata=%h ok=%b want 3 0 1", lat, rd, ok);
    end
    n_tests++;
    if (ha !== 32'h200) begin n_fail++; $display("FAIL strobe_write_awaddr: got %h want 00000200", ha); end
    run_txn(1'b0, 32'h0000_0200, 32'h0, 4'h0, 0, 0, 0, lat, wc, rd, err, rdy, ha, ok);
    n_tests++;
    if (rd !== 32'hFF22_FF44) begin n_fail++; $display("FAIL strobe_readback: got %h want ff22ff44", rd); end
  endtask

  task automatic test_write_stall();
    int lat, wc; logic [31:0] rd, ha; logic err, rdy, ok;
    run_txn(1'b1, 32'h0000_0310, 32'hA5A5_5A5A, 4'b1111, 1, 3, 0, lat, wc, rd, err, rdy, ha, ok);
    ref_write(32'h310, 32'hA5A5_5A5A, 4'b1111);
    n_tests++;
    if (lat !== 6) begin n_fail++; $display("FAIL write_stall_latency: got %0d want 6", lat); end
    n_tests++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL write_stall_protocol: got %b want 1", ok); end
    run_txn(1'b0, 32'h0000_0310, 32'h0, 4'h0, 0, 0, 0, lat, wc, rd, err, rdy, ha, ok);
    n_tests++;
    if (rd !== ref_mem[8'hC4]) begin n_fail++; $display("FAIL write_stall_readback: got %h want %h", rd, ref_mem[8'hC4]); end
  endtask

  task automatic test_ar_stall();
    int lat, wc; logic [31:0] rd, ha; logic err, rdy, ok;
    run_txn(1'b0, 32'h0000_0107, 32'h0, 4'h0, 5, 0, 0, lat, wc, rd, err, rdy, ha, ok);
    n_tests++;
    if (lat !== 8) begin n_fail++; $display("FAIL ar_stall_latency: got %0d want 8", lat); end
    n_tests++;
    if (ok !== 1'b1 || ha !== 32'h104) begin n_fail++; $display("FAIL ar_stall_stable: got ok=%b addr=%h want 1 00000104", ok, ha); end
  endtask

  task automatic test_reset_mid();
    int lat, wc, seen; logic [31:0] rd, ha; logic err, rdy, ok;
    logic [131:0] v;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0104;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    arready = 1'b1;
    @(posedge clk); @(negedge clk);
    arready = 1'b0;
    n_tests++;
    if (rready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_in_rd_r: got rready=%b want 1", rready); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; #1;
    v = {araddr, awaddr, wdata, wstrb, rsp_rdata};
    n_tests++;
    if ({arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err} !== 7'b0 || v !== 132'd0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_outputs: got ctrl=%b data=%h rdy=%b want 0 0 1",
                        {arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err}, v, req_ready);
    end
    seen = 0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      if (rsp_valid) seen++;
    end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("FAIL reset_mid_no_rsp: got %0d pulses want 0", seen); end
    run_txn(1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, 0, 0, lat, wc, rd, err, rdy, ha, ok);
    n_tests++;
    if (rd !== ref_mem[8'h41] || lat !== 3) begin
      n_fail++; $display("FAIL reset_mid_recover: got %h lat=%0d want %h lat=3", rd, lat, ref_mem[8'h41]);
    end
  endtask

  task automatic test_back_to_back();
    int lat, wc; logic [31:0] rd, ha, a, d; logic err, rdy, ok, we;
    for (int i = 0; i < 6; i++) begin
      we = 1'(i % 2); a = 32'($urandom_range(0, 1023)); d = $urandom;
      run_txn(we, a, d, 4'hF, 0, 0, 0, lat, wc, rd, err, rdy, ha, ok);
      if (we) ref_write(a, d, 4'hF);
      n_tests++;
      if (wc !== 0 || lat !== 3) begin
        n_fail++; $display("FAIL back_to_back_%0d: got wait=%0d lat=%0d want 0 3", i, wc, lat);
      end
    end
  endtask

  task automatic test_random();
    int lat, wc, d1, d2, d3; logic [31:0] rd, ha, a, d, exp_rd; logic [3:0] s; logic err, rdy, ok, we;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1)); a = 32'($urandom_range(0, 1023)); d = $urandom;
      s = 4'($urandom_range(0, 15));
      d1 = int'($urandom_range(0, 3)); d2 = int'($urandom_range(0, 3)); d3 = int'($urandom_range(0, 3));
      exp_rd = we ? 32'h0 : ref_mem[a[9:2]];
      run_txn(we, a, d, s, d1, d2, d3, lat, wc, rd, err, rdy, ha, ok);
      if (we) ref_write(a, d, s);
      n_tests++;
      if (lat !== exp_lat(we, d1, d2, d3)) begin
        n_fail++; $display("FAIL rand_latency_%0d: got %0d want %0d", i, lat, exp_lat(we, d1, d2, d3));
      end
      n_tests++;
      if (rd !== exp_rd) begin n_fail++; $display("FAIL rand_rdata_%0d: got %h want %h", i, rd, exp_rd); end
      n_tests++;
      if (ha !== (we ? a : {a[31:2], 2'b00})) begin n_fail++; $display("FAIL rand_addr_%0d: got %h want %h", i, ha, we ? a : {a[31:2], 2'b00}); end
      n_tests++;
      if ({ok, err} !== 2'b10) begin n_fail++; $display("FAIL rand_proto_%0d: got ok=%b err=%b want 1 0", i, ok, err); end
    end
  endtask

`ifdef AXIM_TIMEOUT_EN
  task automatic test_timeout();
    int lat, wc; logic [31:0] rd, ha; logic err, rdy, ok;
    run_txn(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'hF, 0, 0, 1000, lat, wc, rd, err, rdy, ha, ok);
    ref_write(32'h40, 32'h0BAD_F00D, 4'hF);
    n_tests++;
    if (lat !== TO_CYCLES) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", lat, TO_CYCLES); end
    n_tests++;
    if ({err, rdy} !== 2'b11 || rd !== 32'h0) begin
      n_fail++; $display("FAIL timeout_rsp: got err=%b req_ready=%b rdata=%h want 1 1 0", err, rdy, rd);
    end
    run_txn(1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 0, 0, lat, wc, rd, err, rdy, ha, ok);
    n_tests++;
    if (rd !== ref_mem[8'h10] || err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_recover: got %h err=%b want %h 0", rd, err, ref_mem[8'h10]);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    arready = 1'b0; rdata = '0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      slv_mem[i] = $urandom;
      ref_mem[i] = slv_mem[i];
    end
    slv_mem[8'h41] = 32'hDEAD_BEEF; ref_mem[8'h41] = 32'hDEAD_BEEF;
    slv_mem[8'h80] = 32'hFFFF_FFFF; ref_mem[8'h80] = 32'hFFFF_FFFF;
    @(negedge clk);
    test_reset();
    test_sram_read();
    test_strobe_write();
    test_write_stall();
    test_ar_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef AXIM_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got no finish want finish before 500000");
    $fatal(1);
  end

endmodule

`default_nettype wire
